fp16_mul_sequencer: RTL and testbench
=====================================

FP16_MUL_SEQUENCER -- requirements
Module: fp16_mul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port a, input, 16 bits: IEEE-754 half-precision operand A.
REQ-005 SHALL have port b, input, 16 bits: IEEE-754 half-precision operand B.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-008 SHALL have port result, output, 16 bits: product; valid when done=1; held until next accepted start.
REQ-009 SHALL have port ovf, output, 1 bit: overflow flag for the current result.
REQ-010 SHALL have port unf, output, 1 bit: underflow flag for the current result.

Function
REQ-011 SHALL implement states IDLE, MULT, NORM and DONE.
REQ-012 IDLE with start=1 SHALL latch a/b, clear the 22-bit product accumulator and the 4-bit counter, and go to MULT.
REQ-013 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-014 MULT SHALL perform one shift-add step per cycle on the 11-bit significands (hidden 1 prepended), for exactly 11 cycles (counter 0..10), then go to NORM.
REQ-015 NORM SHALL compute the exponent as ea+eb-15 in 7-bit signed arithmetic, plus 1 if product bit 21 is set.
REQ-016 NORM SHALL take the mantissa as product[20:11] if bit 21 is set, else product[19:10] (truncate, round toward zero), register result/ovf/unf, and go to DONE.
REQ-017 DONE SHALL assert done for one cycle and then return to IDLE unconditionally; start in DONE SHALL be ignored.
REQ-018 Fixed latency: start sampled at edge N SHALL give done=1 in the cycle following edge N+12, for all operand values.
REQ-019 Exponent >= 31 SHALL give sign|0x7C00 with ovf=1; exponent <= 0 SHALL give signed zero with unf=1.
REQ-020 Result sign SHALL be a[15] XOR b[15].
REQ-021 Operands with exponent field 0 SHALL be treated as zero (subnormals flushed); a zero operand SHALL give signed zero with ovf=unf=0.
REQ-022 Any NaN operand, or infinity times zero, SHALL give 0x7E00; otherwise an infinity operand SHALL give signed infinity with ovf=0.
REQ-023 Special cases SHALL be detected at accept time and SHALL NOT shorten the latency.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0x0000, ovf=0, unf=0, and clear the counter and accumulator, including mid-operation.
REQ-025 After rst_n deasserts, the first start SHALL be accepted normally; an aborted operation SHALL never produce done.

Structure
REQ-026 Shared package fp16_pkg SHALL hold the state enum and the constants EXP_W=5, MAN_W=10, BIAS=15, EXP_MAX=31, QNAN=16'h7E00 and PINF=16'h7C00.
REQ-027 Normalization extraction (REQ-015/016/019) SHALL be in combinational sub-module fp16_mant_extract, instantiated once.

Verification
REQ-028 0x3C00 x 0x3C00 -> result 0x3C00, ovf=unf=0, done exactly 12 cycles after the start edge.
REQ-029 0x3E00 x 0x3E00 (1.5^2) -> 0x4080; 0xC000 x 0x3C00 -> 0xC000.
REQ-030 0x7BFF x 0x7BFF -> 0x7C00 with ovf=1; 0x0400 x 0x0400 -> 0x0000 with unf=1.
REQ-031 0x7C00 x 0x0000 -> 0x7E00; 0x8000 x 0x3C00 -> 0x8000.
REQ-032 start pulsed again in cycle 5 of MULT with different operands -> first result unchanged and no second done.
REQ-033 rst_n low in cycle 6 of MULT -> outputs zero immediately, no done; next start 0x4000 x 0x4000 -> 0x4400.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision multiply sequencer.
package fp16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          EXP_W   = 5;
  localparam int          MAN_W   = 10;
  localparam int          BIAS    = 15;
  localparam int          EXP_MAX = 31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] PINF    = 16'h7C00;

endpackage

// File: rtl/fp16_mant_extract.sv
// Combinational normalization: exponent sum, mantissa pick (truncating), overflow/underflow saturation.
module fp16_mant_extract
  import fp16_pkg::*;
(
  input  logic [MAN_W+1:0] prod_hi,  // product bits [21:10]
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  input  logic             sign,
  output logic [15:0]      result,
  output logic             ovf,
  output logic             unf
);

  logic signed [6:0]  exp_s;
  logic [MAN_W-1:0]   mant;

  // Exponent in 7-bit signed arithmetic; product bit 21 set means one extra binade.
  always_comb begin
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'(BIAS)
           + (prod_hi[MAN_W+1] ? 7'sd1 : 7'sd0);
    mant   = prod_hi[MAN_W+1] ? prod_hi[MAN_W:1] : prod_hi[MAN_W-1:0];
    ovf    = 1'b0;
    unf    = 1'b0;
    result = {sign, exp_s[EXP_W-1:0], mant};
    if (exp_s >= 7'(EXP_MAX)) begin
      ovf    = 1'b1;
      result = {sign, 15'b0} | PINF;
    end else if (exp_s <= 7'sd0) begin
      unf    = 1'b1;
      result = {sign, 15'b0};
    end
  end

endmodule

// File: rtl/fp16_mul_sequencer.sv
// Sequential FP16 multiplier: 11-cycle shift-add significand product, one normalization cycle, done pulse.
module fp16_mul_sequencer
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        unf
);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam int               PROD_W   = 2 * (MAN_W + 1);

  state_t              state, state_nxt;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   mcand;
  logic [MAN_W:0]      mplier;
  logic [3:0]          cnt;
  logic [EXP_W-1:0]    ea_r, eb_r;
  logic                sign_r;
  logic                spec_r;
  logic [15:0]         spec_val_r;

  logic [EXP_W-1:0]    a_exp, b_exp;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                spec_in;
  logic [15:0]         spec_val_in;
  logic                sign_in;

  logic [15:0]         ext_result;
  logic                ext_ovf, ext_unf;

  // Classify operands at accept time; special results bypass the arithmetic but keep full latency.
  always_comb begin
    a_exp       = a[14:10];
    b_exp       = b[14:10];
    sign_in     = a[15] ^ b[15];
    a_nan       = (a_exp == EXP_ONES) && (a[9:0] != '0);
    b_nan       = (b_exp == EXP_ONES) && (b[9:0] != '0);
    a_inf       = (a_exp == EXP_ONES) && (a[9:0] == '0);
    b_inf       = (b_exp == EXP_ONES) && (b[9:0] == '0);
    a_zero      = (a_exp == '0);
    b_zero      = (b_exp == '0);
    spec_in     = 1'b1;
    spec_val_in = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      spec_val_in = QNAN;
    else if (a_inf || b_inf)
      spec_val_in = {sign_in, 15'b0} | PINF;
    else if (a_zero || b_zero)
      spec_val_in = {sign_in, 15'b0};
    else
      spec_in = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (cnt == 4'd10) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, shift-add product accumulation and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      ea_r       <= '0;
      eb_r       <= '0;
      sign_r     <= 1'b0;
      spec_r     <= 1'b0;
      spec_val_r <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc        <= '0;
          cnt        <= '0;
          mcand      <= {{(PROD_W-MAN_W-1){1'b0}}, 1'b1, a[9:0]};
          mplier     <= {1'b1, b[9:0]};
          ea_r       <= a_exp;
          eb_r       <= b_exp;
          sign_r     <= sign_in;
          spec_r     <= spec_in;
          spec_val_r <= spec_val_in;
        end
        MULT: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        NORM: begin
          result <= spec_r ? spec_val_r : ext_result;
          ovf    <= !spec_r && ext_ovf;
          unf    <= !spec_r && ext_unf;
        end
        default: ;
      endcase
    end
  end

  fp16_mant_extract u_extract (
    .prod_hi (acc[PROD_W-1:MAN_W]),
    .ea      (ea_r),
    .eb      (eb_r),
    .sign    (sign_r),
    .result  (ext_result),
    .ovf     (ext_ovf),
    .unf     (ext_unf)
  );

endmodule

// File: tb/tb_fp16_mul_sequencer.sv
// Scoreboard bench for fp16_mul_sequencer: directed vectors, monitor checks every done pulse.
module tb_fp16_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic        ovf, unf;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          cyc0;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  fp16_mul_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",  32'(result), 32'(e.res));
        check("ovf",     32'(ovf),    32'(e.ovf));
        check("unf",     32'(unf),    32'(e.unf));
        check("latency", 32'(cyc),    32'(e.cyc0 + 12));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] r, input logic o, input logic u);
    exp_t e;
    wait_idle();
    a = ia;
    b = ib;
    start = 1'b1;
    e.res = r; e.ovf = o; e.unf = u; e.cyc0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] r, input logic o, input logic u);
    issue(ia, ib, r, o, u);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_unf",    32'(unf),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0);
    run(16'h3E00, 16'h3E00, 16'h4080, 1'b0, 1'b0);
    run(16'hC000, 16'h3C00, 16'hC000, 1'b0, 1'b0);
    run(16'h3C01, 16'h3C01, 16'h3C02, 1'b0, 1'b0);
    run(16'h4000, 16'hC200, 16'hC600, 1'b0, 1'b0);
    run(16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0);
    run(16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1);
    run(16'h8400, 16'h0400, 16'h8000, 1'b0, 1'b1);
    run(16'h7800, 16'h4000, 16'h7C00, 1'b1, 1'b0);
    run(16'h7800, 16'h3C00, 16'h7800, 1'b0, 1'b0);
    run(16'h0400, 16'h3800, 16'h0000, 1'b0, 1'b1);
    run(16'h0400, 16'h3C00, 16'h0400, 1'b0, 1'b0);
    run(16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0);
    run(16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0);
    run(16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 1'b0);
    run(16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b0);
    run(16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b0);
    run(16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0);

    // Start pulsed during MULT must be ignored.
    issue(16'h3C00, 16'h4000, 16'h4000, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a = 16'h4200;
    b = 16'h4200;
    start = 1'b1;
    check("busy_in_mult", 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check("hold_result", 32'(result), 32'h4000);

    // Reset mid-MULT aborts with no done.
    wait_idle();
    a = 16'h3E00;
    b = 16'h3E00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_ovf",    32'(ovf),    32'd0);
    check("abort_unf",    32'(unf),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(16'h4000, 16'h4000, 16'h4400, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
